// File: rtl/apb_cos_pkg.sv
// apb_cos_pkg: address map, register bit positions, FSM states and the Q1.15 cosine table.
package apb_cos_pkg;
  localparam logic [31:0] ADDR_SCRATCH0 = 32'h00;
  localparam logic [31:0] ADDR_CTRL     = 32'h20;
  localparam logic [31:0] ADDR_DATA     = 32'h24;
  localparam logic [31:0] ADDR_STATUS   = 32'h28;
  localparam int CTRL_K_W    = 3;
  localparam int CTRL_START  = 7;
  localparam int CTRL_IE     = 8;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  typedef enum logic {IDLE, CALC} cos_state_e;
  function automatic logic [15:0] cos_lut(input logic [2:0] k);
    logic [15:0] v;
    case (k)
      3'd0:       v = 16'h7FFF;
      3'd1, 3'd7: v = 16'h5A82;
      3'd2, 3'd6: v = 16'h0000;
      3'd3, 3'd5: v = 16'hA57E;
      default:    v = 16'h8000;
    endcase
    return v;
  endfunction
endpackage

// File: rtl/cos_calc_core.sv
// cos_calc_core: latency-counting cosine engine holding the result and sticky DONE flag.
module cos_calc_core import apb_cos_pkg::*; #(
  parameter int CALC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ack,
  input  logic [2:0]  k_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);
  localparam int CNT_W = CALC_LATENCY > 1 ? $clog2(CALC_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CALC_LATENCY - 1);
  cos_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] k_q, k_d;
  logic [15:0] result_q, result_d;
  logic done_q, done_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    result_d = result_q;
    done_d   = ack ? 1'b0 : done_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CALC;
        k_d     = k_in;
        cnt_d   = CNT_INIT;
        done_d  = 1'b0;
      end
    end else if (cnt_q == '0) begin
      state_d  = IDLE;
      result_d = cos_lut(k_q);
      done_d   = 1'b1;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end
  assign busy   = state_q == CALC;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: rtl/apb_cos_responder.sv
// apb_cos_responder: APB3 completer with four scratch registers and an 8-point cosine engine.
// Defining APB_COS_IRQ_EN adds COS_CTRL.IE and the cos_irq output.
module apb_cos_responder import apb_cos_pkg::*; #(
  parameter int CALC_LATENCY = 4,
  parameter int DATA_W       = 32
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
`ifdef APB_COS_IRQ_EN
  ,
  output logic              cos_irq
`endif
);
  if (DATA_W != 32) begin : g_data_w_check
    $error("apb_cos_responder: DATA_W must be 32");
  end
  if (CALC_LATENCY < 1) begin : g_latency_check
    $error("apb_cos_responder: CALC_LATENCY must be >= 1");
  end
  logic [3:0][DATA_W-1:0] scratch_q, scratch_d;
  logic [CTRL_K_W-1:0] k_q, k_d;
  logic ie;
  logic act, sel_scr, sel_ctrl, sel_data, sel_status, err, access, wr_ok, start, ack;
  logic busy, done;
  logic [15:0] result;
  logic [DATA_W-1:0] ctrl_rd, status_rd, rdata;
  assign act        = PSEL && PRESETn;
  assign sel_scr    = (PADDR & ~32'hC) == ADDR_SCRATCH0;
  assign sel_ctrl   = PADDR == ADDR_CTRL;
  assign sel_data   = PADDR == ADDR_DATA;
  assign sel_status = PADDR == ADDR_STATUS;
  // A START while busy is rejected as a whole, so the k field never lands either.
  assign err = !(sel_scr || sel_ctrl || sel_data || sel_status)
            || (PWRITE && (sel_data || sel_status))
            || (PWRITE && sel_ctrl && PWDATA[CTRL_START] && busy);
  assign PREADY  = !(act && !PWRITE && sel_data && busy);
  assign PSLVERR = act && err;
  assign access  = act && PENABLE && PREADY;
  assign wr_ok   = access && PWRITE && !err;
  assign start   = wr_ok && sel_ctrl && PWDATA[CTRL_START];
  assign ack     = access && !PWRITE && sel_data;
  always_comb begin
    scratch_d = scratch_q;
    if (wr_ok && sel_scr) scratch_d[PADDR[3:2]] = PWDATA;
    k_d = (wr_ok && sel_ctrl) ? PWDATA[CTRL_K_W-1:0] : k_q;
  end
  always_comb begin
    ctrl_rd                     = '0;
    ctrl_rd[CTRL_K_W-1:0]       = k_q;
    ctrl_rd[CTRL_IE]            = ie;
    status_rd                   = '0;
    status_rd[STATUS_BUSY]      = busy;
    status_rd[STATUS_DONE]      = done;
    rdata = sel_scr    ? scratch_q[PADDR[3:2]] :
            sel_ctrl   ? ctrl_rd :
            sel_data   ? {{16{result[15]}}, result} :
            sel_status ? status_rd : '0;
  end
  assign PRDATA = (act && !PWRITE && !err) ? rdata : '0;
`ifdef APB_COS_IRQ_EN
  logic ie_q, ie_d;
  assign ie_d    = (wr_ok && sel_ctrl) ? PWDATA[CTRL_IE] : ie_q;
  assign ie      = ie_q;
  assign cos_irq = done && ie_q;
`else
  assign ie = 1'b0;
`endif
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      scratch_q <= '0;
      k_q       <= '0;
`ifdef APB_COS_IRQ_EN
      ie_q      <= 1'b0;
`endif
    end else begin
      scratch_q <= scratch_d;
      k_q       <= k_d;
`ifdef APB_COS_IRQ_EN
      ie_q      <= ie_d;
`endif
    end
  cos_calc_core #(.CALC_LATENCY(CALC_LATENCY)) u_core (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .start  (start),
    .ack    (ack),
    .k_in   (PWDATA[2:0]),
    .busy   (busy),
    .done   (done),
    .result (result)
  );
endmodule
